// File: rtl/hovalaag_stream_wrapper_if.sv
// Host-side register bus of the Hovalaag stream wrapper: narrow write path, 8-bit registered read path.
interface hovalaag_stream_wrapper_if #(
   parameter int BUS_W = 6
);
   logic [3:0]       addr;
   logic             wr;
   logic [BUS_W-1:0] wdata;
   logic             rd;
   logic [7:0]       rdata;

   modport master (output addr, wr, wdata, rd, input rdata);
   modport slave  (input addr, wr, wdata, rd, output rdata);
endinterface

// File: rtl/hovalaag_stream_wrapper.sv
// Buffered host interface for the Hovalaag core: assembles instruction/input words from the host bus,
// single-steps the core and queues its outputs into per-channel FIFOs for 8-bit readback.
module hovalaag_stream_wrapper #(
   parameter int BUS_W   = 6,
   parameter int INSTR_W = 32,
   parameter int DATA_W  = 12,
   parameter int DEPTH   = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   hovalaag_stream_wrapper_if.slave bus,
   output logic                busy,
   output logic                core_step,
   output logic [INSTR_W-1:0]  core_instr,
   output logic [DATA_W-1:0]   core_in1,
   output logic [DATA_W-1:0]   core_in2,
   input  logic                core_in1_adv,
   input  logic                core_in2_adv,
   input  logic [DATA_W-1:0]   core_out,
   input  logic                core_out_valid,
   input  logic                core_out_select,
   input  logic [7:0]          core_pc
);

   localparam int NCI = (INSTR_W + BUS_W - 1) / BUS_W;
   localparam int NCD = (DATA_W + BUS_W - 1) / BUS_W;
   localparam int CIW = $clog2(NCI + 1);
   localparam int DCW = $clog2(NCD + 1);
   localparam int IBW = (NCI - 1) * BUS_W;
   localparam int ASW = NCD * BUS_W;
   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_STEP = 2'd2;

   logic [1:0]       state;
   logic [CIW-1:0]   ci;
   logic [IBW-1:0]   instr_buf;
   logic [DCW-1:0]   dc1, dc2;
   logic [ASW-1:0]   asm1, asm2, asm1_next, asm2_next;
   logic             ovf, unf, err;

   // FIFO index: 0 = IN1, 1 = IN2, 2 = OUT1, 3 = OUT2
   logic [DATA_W-1:0] mem [4][DEPTH];
   logic [AW-1:0]     rp [4];
   logic [AW-1:0]     wp [4];
   logic [CW-1:0]     cnt [4];
   logic [DATA_W-1:0] pdata [4];
   logic [DATA_W-1:0] head [4];
   logic [3:0]        push, pop, push_ok, pop_ok, full, nonempty;

   logic wr_instr, wr_exec, wr_in1, wr_in2, wr_ctrl;
   logic flush, clear, exec_ok, stepping;
   logic ovf_set, unf_set, err_set;
   logic [7:0] status;

   assign wr_instr = bus.wr && (bus.addr == 4'd0);
   assign wr_exec  = bus.wr && (bus.addr == 4'd1);
   assign wr_in1   = bus.wr && (bus.addr == 4'd2);
   assign wr_in2   = bus.wr && (bus.addr == 4'd3);
   assign wr_ctrl  = bus.wr && (bus.addr == 4'd10);
   assign clear    = wr_ctrl && bus.wdata[0];
   assign flush    = wr_ctrl && bus.wdata[1];
   assign exec_ok  = wr_exec && (state == S_IDLE) && (ci == CIW'(NCI - 1));
   assign stepping = (state == S_STEP);

   assign busy       = (state != S_IDLE);
   assign core_step  = stepping && reset_n;
   assign core_in1   = head[0];
   assign core_in2   = head[1];

   // Chunks enter at the top and shift down, so the first chunk written ends up least significant.
   assign asm1_next = ASW'({bus.wdata, asm1} >> BUS_W);
   assign asm2_next = ASW'({bus.wdata, asm2} >> BUS_W);

   always_comb begin
      for (int unsigned k = 0; k < 4; k++) begin
         full[k]     = (cnt[k] == CW'(DEPTH));
         nonempty[k] = (cnt[k] != '0);
         head[k]     = nonempty[k] ? mem[k][rp[k]] : '0;
      end
      push[0]  = wr_in1 && (dc1 == DCW'(NCD - 1));
      push[1]  = wr_in2 && (dc2 == DCW'(NCD - 1));
      push[2]  = stepping && core_out_valid && !core_out_select;
      push[3]  = stepping && core_out_valid && core_out_select;
      pdata[0] = asm1_next[DATA_W-1:0];
      pdata[1] = asm2_next[DATA_W-1:0];
      pdata[2] = core_out;
      pdata[3] = core_out;
      pop[0]   = stepping && core_in1_adv;
      pop[1]   = stepping && core_in2_adv;
      pop[2]   = bus.rd && (bus.addr == 4'd5);
      pop[3]   = bus.rd && (bus.addr == 4'd7);
      pop_ok   = pop & nonempty;
      // A same-cycle pop frees the slot, so a push into a full FIFO is still accepted.
      push_ok  = push & (~full | pop_ok);
   end

   assign ovf_set = (push[0] && !push_ok[0]) || (push[1] && !push_ok[1]);
   assign unf_set = (pop[0] && !nonempty[0]) || (pop[1] && !nonempty[1]);
   assign err_set = (wr_exec && !exec_ok) || (pop[2] && !nonempty[2]) || (pop[3] && !nonempty[3]);
   assign status  = {err, unf, ovf, busy, nonempty[3], nonempty[2], nonempty[1], nonempty[0]};

   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < 4; k++)
         if (push_ok[k]) mem[k][wp[k]] <= pdata[k];
   end

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         for (int unsigned k = 0; k < 4; k++) begin
            rp[k]  <= '0;
            wp[k]  <= '0;
            cnt[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < 4; k++) begin
            if (push_ok[k]) wp[k] <= wp[k] + 1'b1;
            if (pop_ok[k])  rp[k] <= rp[k] + 1'b1;
            cnt[k] <= cnt[k] + CW'(push_ok[k]) - CW'(pop_ok[k]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ci         <= '0;
         instr_buf  <= '0;
         core_instr <= '0;
         dc1        <= '0;
         dc2        <= '0;
         asm1       <= '0;
         asm2       <= '0;
      end else if (flush) begin
         ci  <= '0;
         dc1 <= '0;
         dc2 <= '0;
      end else begin
         if (wr_instr) begin
            for (int unsigned k = 0; k < NCI - 1; k++)
               if (ci == CIW'(k)) instr_buf[k*BUS_W +: BUS_W] <= bus.wdata;
            if (ci != CIW'(NCI)) ci <= ci + 1'b1;
         end
         if (wr_exec) begin
            ci <= '0;
            if (exec_ok) core_instr <= INSTR_W'({bus.wdata, instr_buf});
         end
         if (wr_in1) begin
            asm1 <= asm1_next;
            dc1  <= (dc1 == DCW'(NCD - 1)) ? '0 : dc1 + 1'b1;
         end
         if (wr_in2) begin
            asm2 <= asm2_next;
            dc2  <= (dc2 == DCW'(NCD - 1)) ? '0 : dc2 + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         ovf <= 1'b0;
         unf <= 1'b0;
         err <= 1'b0;
      end else begin
         ovf <= ovf | ovf_set;
         unf <= unf | unf_set;
         err <= err | err_set;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (exec_ok) state <= S_WAIT;
            S_WAIT:  if (!full[2] && !full[3]) state <= S_STEP;
            S_STEP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bus.rdata <= '0;
      end else if (bus.rd) begin
         case (bus.addr)
            4'd4:    bus.rdata <= head[2][7:0];
            4'd5:    bus.rdata <= 8'(head[2][DATA_W-1:8]);
            4'd6:    bus.rdata <= head[3][7:0];
            4'd7:    bus.rdata <= 8'(head[3][DATA_W-1:8]);
            4'd8:    bus.rdata <= status;
            4'd9:    bus.rdata <= core_pc;
            default: bus.rdata <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_hovalaag_stream_wrapper.sv
// Directed-vector bench for hovalaag_stream_wrapper with hand-computed expectations.
module tb_hovalaag_stream_wrapper;
   localparam int BUS_W   = 6;
   localparam int INSTR_W = 32;
   localparam int DATA_W  = 12;
   localparam int DEPTH   = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   hovalaag_stream_wrapper_if #(.BUS_W(BUS_W)) bus ();

   logic               busy, core_step;
   logic [INSTR_W-1:0] core_instr;
   logic [DATA_W-1:0]  core_in1, core_in2, core_out;
   logic               core_in1_adv, core_in2_adv, core_out_valid, core_out_select;
   logic [7:0]         core_pc;

   hovalaag_stream_wrapper #(
      .BUS_W(BUS_W), .INSTR_W(INSTR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus),
      .busy(busy), .core_step(core_step), .core_instr(core_instr),
      .core_in1(core_in1), .core_in2(core_in2),
      .core_in1_adv(core_in1_adv), .core_in2_adv(core_in2_adv),
      .core_out(core_out), .core_out_valid(core_out_valid),
      .core_out_select(core_out_select), .core_pc(core_pc)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // All bus tasks start and end on a falling edge.
   task automatic bus_wr(input logic [3:0] a, input logic [BUS_W-1:0] d);
      bus.addr = a; bus.wdata = d; bus.wr = 1'b1;
      @(negedge clk);
      bus.wr = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
      bus.addr = a; bus.rd = 1'b1;
      @(negedge clk);
      bus.rd = 1'b0;
      check(tag, bus.rdata, exp);
   endtask

   task automatic load_exec();
      repeat (5) bus_wr(4'd0, 6'h00);
      bus_wr(4'd1, 6'h00);
   endtask

   task automatic step_core();
      load_exec();
      repeat (2) @(negedge clk);
   endtask

   logic [11:0] exp_out2 [4] = '{12'h101, 12'h102, 12'h103, 12'h1A5};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.addr = '0; bus.wr = 1'b0; bus.wdata = '0; bus.rd = 1'b0;
      core_in1_adv = 1'b0; core_in2_adv = 1'b0; core_out = '0;
      core_out_valid = 1'b0; core_out_select = 1'b0; core_pc = 8'h5A;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      check("rst_rdata", bus.rdata, 0);
      check("rst_busy", busy, 0);
      check("rst_step", core_step, 0);
      check("rst_instr", core_instr, 0);
      check("rst_in1", core_in1, 0);
      rd_chk("rst_status", 4'd8, 8'h00);

      // instruction load and exec latency
      repeat (5) bus_wr(4'd0, 6'h3F);
      bus_wr(4'd1, 6'h03);
      check("exec_n1_busy", busy, 1);
      check("exec_n1_step", core_step, 0);
      @(negedge clk);
      check("exec_n2_step", core_step, 1);
      check("instr_ones", core_instr, 32'hFFFF_FFFF);
      @(negedge clk);
      check("exec_n3_step", core_step, 0);
      check("exec_n3_busy", busy, 0);

      // passthrough IN1 -> OUT1
      bus_wr(4'd2, 6'h3C);
      bus_wr(4'd2, 6'h2A);
      check("in1_head", core_in1, 12'hABC);
      rd_chk("status_in1", 4'd8, 8'h01);
      core_in1_adv = 1'b1; core_out_valid = 1'b1; core_out_select = 1'b0; core_out = 12'hABC;
      step_core();
      core_in1_adv = 1'b0; core_out_valid = 1'b0;
      check("in1_popped", core_in1, 0);
      rd_chk("status_out1", 4'd8, 8'h04);
      rd_chk("out1_lo", 4'd4, 8'hBC);
      rd_chk("out1_hi", 4'd5, 8'h0A);
      rd_chk("status_drained", 4'd8, 8'h00);
      rd_chk("pc_read", 4'd9, 8'h5A);
      rd_chk("unmapped", 4'd12, 8'h00);

      // backpressure on OUT2
      core_out_valid = 1'b1; core_out_select = 1'b1;
      for (int i = 0; i < 4; i++) begin
         core_out = 12'h100 + 12'(i);
         step_core();
      end
      rd_chk("status_out2_full", 4'd8, 8'h08);
      core_out = 12'h1A5;
      load_exec();
      for (int i = 0; i < 4; i++) begin
         check("bp_no_step", core_step, 0);
         check("bp_busy", busy, 1);
         @(negedge clk);
      end
      bus_wr(4'd1, 6'h00);
      rd_chk("status_bp_err", 4'd8, 8'h98);
      rd_chk("out2_pop_hi", 4'd7, 8'h01);
      check("pop_m1_step", core_step, 0);
      @(negedge clk);
      check("pop_m2_step", core_step, 1);
      @(negedge clk);
      core_out_valid = 1'b0;
      check("pop_m3_busy", busy, 0);
      for (int i = 0; i < 4; i++) begin
         rd_chk("out2_lo", 4'd6, exp_out2[i][7:0]);
         rd_chk("out2_hi", 4'd7, 8'(exp_out2[i][11:8]));
      end
      rd_chk("out2_empty_pop", 4'd7, 8'h00);
      rd_chk("status_err", 4'd8, 8'h80);
      bus_wr(4'd10, 6'h01);
      rd_chk("status_cleared", 4'd8, 8'h00);

      // EXEC with too few instruction chunks
      repeat (3) bus_wr(4'd0, 6'h15);
      bus_wr(4'd1, 6'h01);
      check("bad_exec_busy", busy, 0);
      check("bad_exec_instr", core_instr, 0);
      rd_chk("bad_exec_status", 4'd8, 8'h80);
      bus_wr(4'd10, 6'h01);

      // IN2 overflow, clear, flush
      for (int i = 0; i < 4; i++) begin
         bus_wr(4'd3, 6'(i + 1));
         bus_wr(4'd3, 6'h00);
      end
      check("in2_head", core_in2, 12'h001);
      rd_chk("status_in2_full", 4'd8, 8'h02);
      bus_wr(4'd3, 6'h3F);
      bus_wr(4'd3, 6'h3F);
      rd_chk("status_ovf", 4'd8, 8'h22);
      bus_wr(4'd10, 6'h01);
      rd_chk("status_ovf_clr", 4'd8, 8'h02);
      bus_wr(4'd10, 6'h02);
      rd_chk("status_flush", 4'd8, 8'h00);
      check("in2_flushed", core_in2, 0);

      // IN1 underflow
      core_in1_adv = 1'b1;
      check("unf_in1_zero", core_in1, 0);
      step_core();
      core_in1_adv = 1'b0;
      rd_chk("status_unf", 4'd8, 8'h40);
      bus_wr(4'd10, 6'h01);

      // host push collides with step pop of the single IN1 entry
      bus_wr(4'd2, 6'h23);
      bus_wr(4'd2, 6'h04);
      check("coll_head0", core_in1, 12'h123);
      bus_wr(4'd2, 6'h16);
      core_in1_adv = 1'b1;
      load_exec();
      @(negedge clk);
      check("coll_step", core_step, 1);
      check("coll_head_old", core_in1, 12'h123);
      bus_wr(4'd2, 6'h11);
      core_in1_adv = 1'b0;
      check("coll_head_new", core_in1, 12'h456);
      rd_chk("coll_status", 4'd8, 8'h01);
      core_in1_adv = 1'b1;
      step_core();
      core_in1_adv = 1'b0;
      check("coll_drained", core_in1, 0);
      rd_chk("coll_single", 4'd8, 8'h00);

      // reset during a pending step
      bus_wr(4'd2, 6'h01);
      bus_wr(4'd2, 6'h00);
      core_out_valid = 1'b1; core_out_select = 1'b0; core_out = 12'h0FF;
      step_core();
      core_out_valid = 1'b0;
      rd_chk("pre_rst_status", 4'd8, 8'h05);
      repeat (5) bus_wr(4'd0, 6'h2A);
      bus_wr(4'd1, 6'h01);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("rst_step_gated", core_step, 0);
      @(negedge clk);
      reset_n = 1'b1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_rdata", bus.rdata, 0);
      check("mid_rst_instr", core_instr, 0);
      check("mid_rst_in1", core_in1, 0);
      rd_chk("mid_rst_status", 4'd8, 8'h00);
      @(negedge clk);
      check("mid_rst_no_step", core_step, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/hovalaag_stream_wrapper.md
# hovalaag_stream_wrapper

- Parametrised, buffered host interface for the Hovalaag core.
- Assembles instruction and input words from a narrow host write bus and queues input words in per-channel FIFOs.
- Single-steps the core under a small state machine and captures core outputs into per-channel output FIFOs, read back over an 8-bit bus.
- Sits between the pad-level host bus and the core; the core is instantiated alongside, not inside, this block.

## Interface
- BUS_W, 6: host write data width.
- INSTR_W, 32: instruction width; NCI = ceil(INSTR_W/BUS_W) chunks.
- DATA_W, 12: IN/OUT word width, 9..16; NCD = ceil(DATA_W/BUS_W) chunks.
- DEPTH, 4: entries per FIFO, power of two, ≥2.

Ports (clock and reset first):
- clk  in  1  single clock for block and core.
- reset_n  in  1  synchronous, active-low reset.
- addr  in  4  register address, binary.
- wr  in  1  write strobe; wdata written to addr.
- wdata  in  BUS_W  write data.
- rd  in  1  read strobe.
- rdata  out  8  registered read data.
- busy  out  1  exec pending or stepping.
- core_step  out  1  one-cycle core clock-enable.
- core_instr  out  INSTR_W  assembled instruction, held stable.
- core_in1, core_in2  out  DATA_W  head of IN1/IN2 FIFO; 0 if empty.
- core_in1_adv, core_in2_adv  in  1  core consumes IN1/IN2 this step.
- core_out  in  DATA_W  core OUT value.
- core_out_valid, core_out_select  in  1  OUT valid; 0=OUT1, 1=OUT2.
- core_pc  in  8  core program counter.

## Operation
- Write map:
  - 0 INSTR: wdata → chunk ci of instr register; ci++.
  - 1 EXEC: wdata → chunk NCI-1, excess bits truncated; ci=0; request execution.
  - 2 IN1: shift chunk into IN1 assembler, LSB chunk first.
  - 3 IN2: as IN2.
  - 10 CTRL: bit0 clears sticky flags; bit1 flushes all FIFOs and zeroes ci and both data chunk counters.
- Read map:
  - 4: OUT1 head[7:0], no pop.
  - 5: OUT1 head[DATA_W-1:8] zero-extended, then pop.
  - 6, 7: same for OUT2.
  - 8: STATUS.
  - 9: core_pc.
  - Other addresses read 0.
- Data assembly: after NCD chunks the word is pushed to its FIFO. Push to a full FIFO drops the word and sets OVF.
- STATUS bits:
  - [0] IN1 nonempty, [1] IN2 nonempty, [2] OUT1 nonempty, [3] OUT2 nonempty, [4] busy.
  - [5] OVF: input push to full FIFO.
  - [6] UNF: core adv on empty input FIFO.
  - [7] ERR: EXEC while busy, EXEC with ci≠NCI-1, or pop of empty OUT FIFO (returns 0).
- FSM IDLE/WAIT/STEP, reset to IDLE:
  - IDLE: valid EXEC → WAIT. Invalid EXEC sets ERR, stays IDLE, instr unchanged.
  - WAIT: OUT1 and OUT2 both not full → STEP; else stay.
  - STEP: core_step=1. Pop IN1 if core_in1_adv, pop IN2 if core_in2_adv (UNF if empty). If core_out_valid, push core_out to the FIFO chosen by select; room is guaranteed. → IDLE.
- busy = state≠IDLE.
- Simultaneous events:
  - Host write to IN FIFO in the STEP cycle that pops it: both occur; count unchanged if nonempty. Full + pop + push: push accepted.
  - Host pop in the STEP cycle that pushes the same OUT FIFO: both occur.
  - CTRL flush wins over all same-cycle pushes/pops; the FSM is not affected.
  - CTRL clear wins over same-cycle flag sets.

## Timing
- Reset: rdata=0, busy=0, core_step=0, core_instr=0, FIFOs empty, counters 0, flags 0, state IDLE; core_in1/core_in2 therefore 0.
- Writes take effect at the edge ending the wr cycle.
- Reads: rdata valid the cycle after rd; pop occurs at that same edge. rdata holds until the next rd.
- Exec latency, EXEC at cycle N with FIFOs not full: WAIT at N+1, core_step high at N+2, IDLE and STATUS updated at N+3.
- Minimum step period is 3 cycles.
- The core samples core_* inputs at the core_step edge; core_* input ports are combinational from core state and are sampled by this block in the STEP cycle.
- Reset mid-operation: next edge returns everything to reset values. A pending step is abandoned; core_step is never asserted in the reset cycle.

## Test plan
- Reset with all FIFOs written: hold reset_n=0 one cycle → STATUS=0x00, rdata=0, core_instr=0.
- Instr load, defaults: 5×INSTR 0x3F then EXEC 0x3 → core_instr=0xFFFFFFFF; core_step high exactly at N+2.
- Passthrough: push IN1 0xABC as chunks 0x3C,0x2A; step with core_in1_adv=1, core_out_valid=1, select=0, core_out=0xABC → read 4=0xBC, read 5=0x0A, then STATUS[2]=0.
- Backpressure: fill OUT2 (DEPTH=4) via 4 steps; EXEC → busy stays 1, no core_step. Pop OUT2 once → core_step 2 cycles later.
- Errors:
  - 5th IN2 word into full FIFO → OVF.
  - adv on empty IN1 with core_in1=0 → UNF.
  - EXEC while busy → ERR.
  - CTRL 0x1 → STATUS flags clear.
- Collision: write IN1 last chunk in the STEP cycle popping the single IN1 entry → IN1 count stays 1, holding the new word.
